// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI slave receiver, oversampled in the pclk domain.
// Deserialises 8..16-bit words in any CPOL/CPHA/bit-order mode and hands each
// word over a valid/ready handshake with sticky overrun and abort status.
// Optional MISO return shifter: define SPI_SLAVE_MISO_EN to build it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | not selected; bit counter held at 0, miso low
// SHIFT | selected; sample edges shift mosi in, words may run back-to-back
module spi_slave_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        cpol,
    input  logic        cpha,
    input  logic        lsbf,
    input  logic [3:0]  bits,
    input  logic        sck,
    input  logic        ssel,
    input  logic        mosi,
    output logic        miso,
    input  logic [15:0] tx_data,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        ovr,
    output logic        abort,
    input  logic        ovr_clr
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // 0 means 16, 1..7 are promoted to the minimum word length of 8
    function automatic logic [4:0] decode_bits(input logic [3:0] b);
        if (b == 4'd0) begin
            return 5'd16;
        end else if (b < 4'd8) begin
            return 5'd8;
        end else begin
            return {1'b0, b};
        end
    endfunction

    function automatic logic [3:0] msb_index(input logic [4:0] n);
        logic [4:0] m;
        m = n - 5'd1;
        return m[3:0];
    endfunction

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ssel_sync_q, ssel_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_h_q, sck_h_d;
    logic                   ssel_h_q, ssel_h_d;
    logic [SYNC_STAGES:0]   flush_q, flush_d;
    logic                   armed_q, armed_d;

    logic sck_s, ssel_s, mosi_s;
    logic mode_x, sck_chg, sample_edge, launch_edge;
    logic ssel_fall, ssel_rise;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] rx_sh_q, rx_sh_d;
    logic        cpol_q, cpol_d;
    logic        cpha_q, cpha_d;
    logic        lsbf_q, lsbf_d;
    logic [4:0]  nbits_q, nbits_d;
    logic [15:0] rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        ovr_q, ovr_d;
    logic        abort_q, abort_d;
    logic        ovr_set;
    logic        word_done;
    logic [3:0]  msb_q;
    logic [15:0] sh_next;

    // synchroniser chains plus history flops; flush marks when the history flop
    // first holds a value that really came from the pin after reset
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        ssel_sync_d = {ssel_sync_q[SYNC_STAGES-2:0], ssel};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sck_h_d     = sck_sync_q[SYNC_STAGES-1];
        ssel_h_d    = ssel_sync_q[SYNC_STAGES-1];
        flush_d     = {flush_q[SYNC_STAGES-1:0], 1'b1};
        // a frame already running at reset release is ignored until ssel is seen high
        armed_d     = armed_q | (flush_q[SYNC_STAGES] & ssel_h_q);
    end

    // register the synchroniser chains
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sck_sync_q  <= '0;
            ssel_sync_q <= '1;
            mosi_sync_q <= '0;
            sck_h_q     <= 1'b0;
            ssel_h_q    <= 1'b1;
            flush_q     <= '0;
            armed_q     <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            ssel_sync_q <= ssel_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_h_q     <= sck_h_d;
            ssel_h_q    <= ssel_h_d;
            flush_q     <= flush_d;
            armed_q     <= armed_d;
        end
    end

    // edge classification on the synchronised pins, using the latched mode
    always_comb begin
        sck_s       = sck_sync_q[SYNC_STAGES-1];
        ssel_s      = ssel_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        mode_x      = cpol_q ^ cpha_q;
        sck_chg     = sck_s ^ sck_h_q;
        sample_edge = sck_chg & (sck_s == ~mode_x);
        launch_edge = sck_chg & (sck_s == mode_x);
        ssel_fall   = armed_q & ssel_h_q & ~ssel_s;
        ssel_rise   = ~ssel_h_q & ssel_s;
        msb_q       = msb_index(nbits_q);
        if (lsbf_q) begin
            sh_next = (rx_sh_q >> 1) | (16'(mosi_s) << msb_q);
        end else begin
            sh_next = {rx_sh_q[14:0], mosi_s};
        end
    end

    // receive FSM next-state, handshake and status
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsbf_d     = lsbf_q;
        nbits_d    = nbits_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        abort_d    = 1'b0;
        ovr_set    = 1'b0;
        word_done  = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = 5'd0;
                if (ssel_fall) begin
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsbf_d  = lsbf;
                    nbits_d = decode_bits(bits);
                    rx_sh_d = 16'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ssel_rise) begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                    rx_sh_d = 16'd0;
                    abort_d = (cnt_q != 5'd0);
                end else if (sample_edge) begin
                    if (cnt_q + 5'd1 == nbits_q) begin
                        word_done = 1'b1;
                        cnt_d     = 5'd0;
                        rx_sh_d   = 16'd0;
                    end else begin
                        cnt_d   = cnt_q + 5'd1;
                        rx_sh_d = sh_next;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase

        // a completing word may replace one being accepted in the same cycle
        if (word_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = sh_next;
                rx_valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end

        ovr_d = ovr_set | (ovr_q & ~ovr_clr);
    end

    // receive FSM state and registered outputs
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            rx_sh_q    <= 16'd0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsbf_q     <= 1'b0;
            nbits_q    <= 5'd8;
            rx_data_q  <= 16'd0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_sh_q    <= rx_sh_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsbf_q     <= lsbf_d;
            nbits_q    <= nbits_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            abort_q    <= abort_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign ovr      = ovr_q;
    assign abort    = abort_q;

`ifdef SPI_SLAVE_MISO_EN
    logic [15:0] tx_sh_q, tx_sh_d;
    logic        miso_q, miso_d;
    logic [3:0]  msb_in;

    // TX shifter holds bits not yet driven; a launch edge drives the head bit.
    // With CPHA=0 the first bit is driven straight away at the ssel fall.
    always_comb begin
        tx_sh_d = tx_sh_q;
        miso_d  = miso_q;
        msb_in  = msb_index(decode_bits(bits));
        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ssel_fall) begin
                    if (cpha) begin
                        tx_sh_d = tx_data;
                    end else if (lsbf) begin
                        miso_d  = tx_data[0];
                        tx_sh_d = tx_data >> 1;
                    end else begin
                        miso_d  = tx_data[msb_in];
                        tx_sh_d = tx_data << 1;
                    end
                end
            end
            SHIFT: begin
                if (ssel_rise) begin
                    miso_d = 1'b0;
                end else if (word_done) begin
                    tx_sh_d = tx_data;
                end else if (launch_edge) begin
                    if (lsbf_q) begin
                        miso_d  = tx_sh_q[0];
                        tx_sh_d = tx_sh_q >> 1;
                    end else begin
                        miso_d  = tx_sh_q[msb_q];
                        tx_sh_d = tx_sh_q << 1;
                    end
                end
            end
            default: begin
                miso_d = 1'b0;
            end
        endcase
    end

    // register the TX shifter and miso drive
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tx_sh_q <= 16'd0;
            miso_q  <= 1'b0;
        end else begin
            tx_sh_q <= tx_sh_d;
            miso_q  <= miso_d;
        end
    end

    assign miso = miso_q;
`else
    logic unused_tx;
    assign unused_tx = ^{tx_data, launch_edge};
    assign miso      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives SPI frames as a master would and
// checks received words, handshake, overrun, abort, reset and MISO return.
module tb_spi_slave_rx;
    localparam int HALF = 8;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        cpol = 1'b0, cpha = 1'b0, lsbf = 1'b0;
    logic [3:0]  bits = 4'd8;
    logic        sck = 1'b0, ssel = 1'b1, mosi = 1'b0;
    logic        miso;
    logic [15:0] tx_data = 16'h0000;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic        ovr, abort;
    logic        ovr_clr = 1'b0;

    int total = 0;
    int bad = 0;
    int abort_cyc = 0;
    logic miso_seen = 1'b0;
    logic [15:0] acc_q[$];
    logic [15:0] got;

    always #5 pclk = ~pclk;

    spi_slave_rx #(.SYNC_STAGES(2)) dut (
        .pclk(pclk), .presetn(presetn),
        .cpol(cpol), .cpha(cpha), .lsbf(lsbf), .bits(bits),
        .sck(sck), .ssel(ssel), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .ovr(ovr), .abort(abort), .ovr_clr(ovr_clr)
    );

    // observe accepted words, abort cycles and any miso activity away from the active edge
    always @(negedge pclk) begin
        if (rx_valid === 1'b1 && rx_ready === 1'b1) acc_q.push_back(rx_data);
        if (abort === 1'b1) abort_cyc++;
        if (miso === 1'b1) miso_seen = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    function automatic logic [15:0] acc_at(input int idx);
        if (idx < acc_q.size()) return acc_q[idx];
        return 16'hxxxx;
    endfunction

    // master model: up to two words of n bits packed as w[15:0], w[31:16]
    task automatic spi_frame(input logic [31:0] w, input int n, input int nsend,
                             input logic p, input logic h, input logic l,
                             input logic keep_sel, output logic [15:0] rcv);
        logic [3:0] gb;
        logic       kk;
        rcv  = 16'h0000;
        cpol = p; cpha = h; lsbf = l; sck = p;
        wait_clk(4);
        ssel = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nsend; i++) begin
            kk = (i >= n);
            gb = 4'(l ? (i % n) : (n - 1 - (i % n)));
            if (!h) begin
                mosi = w[{kk, gb}];
                wait_clk(HALF);
                sck = ~p;
                if (!kk) rcv[gb] = miso;
                wait_clk(HALF);
                sck = p;
            end else begin
                sck = ~p;
                mosi = w[{kk, gb}];
                wait_clk(HALF);
                sck = p;
                if (!kk) rcv[gb] = miso;
                wait_clk(HALF);
            end
        end
        wait_clk(HALF);
        if (!keep_sel) begin
            ssel = 1'b1;
            wait_clk(HALF);
        end
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        wait_clk(3);
        total++; if (rx_data !== 16'h0000) begin bad++; $display("FAIL reset_rx_data: got %h expected 0000", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
        total++; if (abort !== 1'b0) begin bad++; $display("FAIL reset_abort: got %b expected 0", abort); end
        total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b expected 0", miso); end
        presetn = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_mode0();
        acc_q.delete();
        rx_ready = 1'b1; bits = 4'd8;
        spi_frame(32'h00A5, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, got);
        wait_clk(4);
        total++; if (acc_q.size() != 1) begin bad++; $display("FAIL mode0_count: got %0d expected 1", acc_q.size()); end
        total++; if (acc_at(0) !== 16'h00A5) begin bad++; $display("FAIL mode0_data: got %h expected 00a5", acc_at(0)); end
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL mode0_ovr: got %b expected 0", ovr); end
    endtask

    task automatic test_mode3_lsb();
        acc_q.delete();
        bits = 4'd12;
        spi_frame(32'h05A3, 12, 12, 1'b1, 1'b1, 1'b1, 1'b0, got);
        bits = 4'd0;
        spi_frame(32'hBEEF, 16, 16, 1'b1, 1'b1, 1'b1, 1'b0, got);
        wait_clk(4);
        total++; if (acc_q.size() != 2) begin bad++; $display("FAIL mode3_count: got %0d expected 2", acc_q.size()); end
        total++; if (acc_at(0) !== 16'h05A3) begin bad++; $display("FAIL mode3_12bit: got %h expected 05a3", acc_at(0)); end
        total++; if (acc_at(1) !== 16'hBEEF) begin bad++; $display("FAIL mode3_16bit: got %h expected beef", acc_at(1)); end
    endtask

    task automatic test_back_to_back();
        acc_q.delete();
        bits = 4'd8;
        spi_frame(32'h0034_0012, 8, 16, 1'b0, 1'b0, 1'b0, 1'b0, got);
        wait_clk(4);
        total++; if (acc_q.size() != 2) begin bad++; $display("FAIL b2b_count: got %0d expected 2", acc_q.size()); end
        total++; if (acc_at(0) !== 16'h0012) begin bad++; $display("FAIL b2b_word0: got %h expected 0012", acc_at(0)); end
        total++; if (acc_at(1) !== 16'h0034) begin bad++; $display("FAIL b2b_word1: got %h expected 0034", acc_at(1)); end
    endtask

    task automatic test_overrun();
        acc_q.delete();
        rx_ready = 1'b0; bits = 4'd8;
        spi_frame(32'h0011, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, got);
        spi_frame(32'h0022, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, got);
        wait_clk(4);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid_held: got %b expected 1", rx_valid); end
        total++; if (rx_data !== 16'h0011) begin bad++; $display("FAIL ovr_data_kept: got %h expected 0011", rx_data); end
        total++; if (ovr !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b expected 1", ovr); end
        rx_ready = 1'b1; ovr_clr = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0; ovr_clr = 1'b0;
        wait_clk(2);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_valid_cleared: got %b expected 0", rx_valid); end
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL ovr_cleared: got %b expected 0", ovr); end
        total++; if (acc_q.size() != 1) begin bad++; $display("FAIL ovr_accepts: got %0d expected 1", acc_q.size()); end
        rx_ready = 1'b1;
    endtask

    task automatic test_abort();
        acc_q.delete();
        abort_cyc = 0; bits = 4'd8;
        spi_frame(32'h003C, 8, 5, 1'b0, 1'b0, 1'b0, 1'b0, got);
        wait_clk(6);
        total++; if (abort_cyc != 1) begin bad++; $display("FAIL abort_width: got %0d cycles expected 1", abort_cyc); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL abort_no_valid: got %b expected 0", rx_valid); end
        total++; if (acc_q.size() != 0) begin bad++; $display("FAIL abort_no_word: got %0d expected 0", acc_q.size()); end
        spi_frame(32'h003C, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, got);
        wait_clk(4);
        total++; if (acc_at(0) !== 16'h003C) begin bad++; $display("FAIL abort_next_word: got %h expected 003c", acc_at(0)); end
        total++; if (abort_cyc != 1) begin bad++; $display("FAIL abort_full_frame: got %0d cycles expected 1", abort_cyc); end
    endtask

    task automatic test_reset_mid();
        bits = 4'd8;
        spi_frame(32'h00F0, 8, 4, 1'b0, 1'b0, 1'b0, 1'b1, got);
        presetn = 1'b0;
        wait_clk(2);
        total++; if (rx_data !== 16'h0000) begin bad++; $display("FAIL rstmid_rx_data: got %h expected 0000", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_rx_valid: got %b expected 0", rx_valid); end
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL rstmid_ovr: got %b expected 0", ovr); end
        total++; if (abort !== 1'b0) begin bad++; $display("FAIL rstmid_abort: got %b expected 0", abort); end
        total++; if (miso !== 1'b0) begin bad++; $display("FAIL rstmid_miso: got %b expected 0", miso); end
        presetn = 1'b1;
        wait_clk(10);
        acc_q.delete();
        spi_frame(32'h00FF, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, got);
        wait_clk(4);
        total++; if (acc_q.size() != 0) begin bad++; $display("FAIL rstmid_stale_frame: got %0d words expected 0", acc_q.size()); end
        spi_frame(32'h0081, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, got);
        wait_clk(4);
        total++; if (acc_at(0) !== 16'h0081) begin bad++; $display("FAIL rstmid_fresh: got %h expected 0081", acc_at(0)); end
    endtask

    task automatic test_miso();
        acc_q.delete();
        bits = 4'd8; tx_data = 16'h00C3;
        spi_frame(32'h003C, 8, 8, 1'b0, 1'b1, 1'b0, 1'b0, got);
        wait_clk(4);
        total++; if (acc_at(0) !== 16'h003C) begin bad++; $display("FAIL miso_rx_data: got %h expected 003c", acc_at(0)); end
`ifdef SPI_SLAVE_MISO_EN
        total++; if (got !== 16'h00C3) begin bad++; $display("FAIL miso_capture: got %h expected 00c3", got); end
`else
        total++; if (got !== 16'h0000) begin bad++; $display("FAIL miso_capture: got %h expected 0000", got); end
        total++; if (miso_seen !== 1'b0) begin bad++; $display("FAIL miso_idle: got %b expected 0", miso_seen); end
`endif
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3_lsb();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_miso();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI slave receiver: the far end of the APB-to-SPI master link. Oversamples `sck`, `ssel` and `mosi` in the `pclk` domain, deserialises 8–16-bit words in any CPOL/CPHA/bit-order mode, and hands each completed word to the local side over a valid/ready handshake with sticky overrun and abort status. An optional MISO shifter returns a word to the master in the same frame. Used as the bus-functional partner of the SPI master and as a reusable slave in SoC tops.

## Interface
Parameters
- `SYNC_STAGES`, 2: synchroniser depth on `sck`, `ssel`, `mosi`. Legal values are 2 or 3.

Ports
- `pclk`  in  1  sole clock. Must run at ≥ 6× `sck` frequency.
- `presetn`  in  1  reset, asynchronous assert, active-low.
- `cpol`, `cpha`, `lsbf`  in  1 each  mode controls; must be stable while `ssel` is low.
- `bits`  in  4  word length: 0 = 16, 8–15 as-is, 1–7 treated as 8.
- `sck`, `ssel`, `mosi`  in  1 each  SPI pins, asynchronous to `pclk`.
- `miso`  out  1  slave data out; driven 0 when not selected.
- `tx_data`  in  16  word returned on `miso`.
- `rx_data`  out  16  received word, right-justified, upper bits 0.
- `rx_valid`  out  1  `rx_data` holds an unconsumed word.
- `rx_ready`  in  1  consumer accepts the word.
- `ovr`  out  1  sticky: a word was lost.
- `abort`  out  1  one-cycle pulse: `ssel` rose mid-word.
- `ovr_clr`  in  1  clears `ovr`.

## Operation
- Synchronisers: each pin passes through `SYNC_STAGES` flops, then one more history flop used for edge detection. All three pins use equal depth, so `mosi` is aligned with `sck`.
- Sample edge: a synced `sck` change where the new value equals `!(cpol^cpha)`.
- Launch edge: a synced `sck` change where the new value equals `cpol^cpha`.
- FSM states are IDLE and SHIFT.
- IDLE:
  - Bit counter is 0.
  - On a synced `ssel` falling edge: latch `cpol`/`cpha`/`lsbf`/`bits`, load `tx_data` into the TX shifter, and go to SHIFT.
- SHIFT:
  - On a sample edge: shift in `mosi`. MSB-first shifts left, inserting at bit 0. LSB-first inserts at bit `nbits-1` and shifts right. Counter increments.
  - When the counter reaches `nbits` (same cycle as the last shift):
    - Word completes and the counter resets to 0.
    - Remain in SHIFT, so back-to-back words within one `ssel` frame are legal.
    - Reload the TX shifter from `tx_data`.
  - On a synced `ssel` rising edge: return to IDLE. If the counter is nonzero, the partial word is discarded and `abort` pulses.
- Word completion: load `rx_data` and set `rx_valid`, unless `rx_valid` is 1 and `rx_ready` is 0. In that case `rx_data` is kept, the new word is dropped, and `ovr` is set.
- Handshake: `rx_valid` falls in the cycle after `rx_valid && rx_ready`. If a completion coincides with an accept, the new word loads, `rx_valid` stays 1 and `ovr` does not set.
- `ovr`: stays set until `ovr_clr`. If a set and a clear happen in the same cycle, set wins.
- Reset (`presetn` low, any time, including mid-word): FSM goes to IDLE. Outputs take these values: `rx_data`=0, `rx_valid`=0, `ovr`=0, `abort`=0, `miso`=0. The synchroniser flops reset `ssel` to 1 and `sck` to 0. A frame in progress at reset release is ignored until `ssel` has been seen high, then low again.

## Timing
- Pin-to-detect delay is `SYNC_STAGES`+1 `pclk` cycles.
- `rx_valid` rises 1 cycle after the cycle in which the final sample edge is detected.
- Setup requirement: each `sck` level must last ≥ 3 `pclk` cycles. This equals a master divider value ≥ 2.
- `mosi` must be stable for ≥ 1 `pclk` before and after its sample edge at the pins.
- `abort` is high exactly 1 cycle, in the cycle after the `ssel` rise is detected.

## Configuration
- `SPI_SLAVE_MISO_EN` defined:
  - TX shifter and `miso` drive are compiled in.
  - CPHA=0: the first bit appears on `miso` in the cycle after the synced `ssel` fall. Later bits change on launch edges.
  - CPHA=1: each bit, including the first, appears on a launch edge.
  - Bit order follows the latched `lsbf`.
- `SPI_SLAVE_MISO_EN` undefined:
  - No TX shifter is built.
  - `miso` is tied to 0 and `tx_data` is ignored.
  - Receive behaviour is identical.

## Test plan
- Mode 0, `bits`=8, MSB-first, master sends 0xA5 with `rx_ready`=1 → one `rx_valid` pulse, `rx_data`=0x00A5, `ovr`=0.
- Mode 3, `lsbf`=1, `bits`=12, master sends 0x5A3 → `rx_data`=0x05A3. Repeat with `bits`=0 and 0xBEEF → `rx_data`=0xBEEF.
- `rx_ready`=0, master sends 0x11 then 0x22 → `rx_data` stays 0x11 and `ovr`=1. Then pulse `rx_ready` and `ovr_clr` → `rx_valid`=0, `ovr`=0.
- `ssel` raised after 5 sample edges → `abort` high for 1 cycle, `rx_valid` stays 0. The next full 0x3C frame → `rx_data`=0x003C.
- `presetn` pulsed low after 4 bits of a frame → all outputs 0. `ssel` high, then a fresh 0x81 frame → `rx_data`=0x0081.
- `SPI_SLAVE_MISO_EN` defined, mode 1, `tx_data`=0xC3, master sends 0x3C → master captures 0xC3 and `rx_data`=0x3C. Without the macro, `miso` stays 0 throughout.
